// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU load/store port: one request at a time over
// req/ack, WAIT_CYCLES wait states, sub-word access with optional sign extension.
module dmem_responder #(
    parameter int MEMSIZE     = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [1:0]  op,
    input  logic        sext,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam int WORDS = MEMSIZE / 4;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              commit;

    logic              we_p0, sext_p0;
    logic [31:0]       addr_p0, wdata_p0;
    logic [1:0]        op_p0;

    logic              we_c, sext_c, err_c;
    logic [31:0]       addr_c, wdata_c;
    logic [1:0]        op_c;
    logic [IDX_W-1:0]  idx_c;
    logic [31:0]       word_c, load_c, store_c;

    logic [31:0]       mem [WORDS];

    function automatic logic access_err(input logic [31:0] a, input logic [1:0] size);
        logic bad;
        bad = (size == 2'b11) ||
              (size == 2'b01 && a[0]) ||
              (size == 2'b00 && a[1:0] != 2'b00) ||
              (a >= 32'(MEMSIZE));
        return bad;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                                 input logic [1:0] size, input logic sx);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b01:   r = sx ? 32'(h) : {16'b0, h};
            2'b10:   r = sx ? 32'(b) : {24'b0, b};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                                input logic [1:0] lane, input logic [1:0] size);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00: r = wd;
            2'b01: begin
                if (lane[1]) r[31:16] = wd[15:0];
                else         r[15:0]  = wd[15:0];
            end
            2'b10:   r[{lane, 3'b000} +: 8] = wd[7:0];
            default: r = word;
        endcase
        return r;
    endfunction

    // With zero wait states the commit edge is the accepting edge, so it sees the live inputs
    always_comb begin
        if (state == IDLE) begin
            we_c = we;    sext_c = sext;    addr_c = addr;    wdata_c = wdata;    op_c = op;
        end else begin
            we_c = we_p0; sext_c = sext_p0; addr_c = addr_p0; wdata_c = wdata_p0; op_c = op_p0;
        end
        err_c   = access_err(addr_c, op_c);
        idx_c   = addr_c[IDX_W+1:2];
        word_c  = mem[idx_c];
        load_c  = load_extract(word_c, addr_c[1:0], op_c, sext_c);
        store_c = store_merge(word_c, wdata_c, addr_c[1:0], op_c);
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_nxt = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rdata <= 32'd0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (commit) begin
                err   <= err_c;
                rdata <= (err_c || we_c) ? 32'd0 : load_c;
            end
        end
    end

    // Request capture at acceptance
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            we_p0    <= we;
            sext_p0  <= sext;
            addr_p0  <= addr;
            wdata_p0 <= wdata;
            op_p0    <= op;
        end
    end

    // Array is not reset; writes only on a clean commit edge
    always_ff @(posedge clk) begin
        if (rst && commit && we_c && !err_c)
            mem[idx_c] <= store_c;
    end

    assign ack  = (state == RESP);
    assign busy = (state != IDLE);

endmodule
